mul_seq_csa: RTL and testbench

- Sequential radix-2 shift-add unsigned multiplier.
- Each cycle it presents the upper half of its partial product and the multiplicand to a combinational conditional-sum adder, then shifts the result back in.
- Takes WIDTH-bit operands via a valid/ready handshake and returns a 2*WIDTH-bit product via valid/ready after WIDTH iterations.
- Sits in the arithmetic datapath as the multi-cycle consumer of the conditional-sum adder.

---
 rtl/mul_seq_csa_pkg.sv | 16 +
 rtl/mul_seq_csa_if.sv | 25 ++
 rtl/mul_seq_csa_csa.sv | 52 +++++
 rtl/mul_seq_csa.sv | 95 +++++++++
 tb/tb_mul_seq_csa.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_csa_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding
// and the helper that sizes the iteration counter.
package mul_seq_csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // One extra bit so the counter can represent WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_seq_csa_if.sv
// Operand/product handshake bundle for mul_seq_csa.
interface mul_seq_csa_if #(
  parameter int WIDTH = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/mul_seq_csa_csa.sv
// Conditional-sum adder: recursively halves the operands and produces both the
// carry-in=0 (s0/co0) and carry-in=1 (s1/co1) results at every level.
module mul_seq_csa_csa #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s0,
  output logic             co0,
  output logic [WIDTH-1:0] s1,
  output logic             co1
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign s0  = x ^ y;
      assign co0 = x & y;
      assign s1  = ~(x ^ y);
      assign co1 = x | y;
    end else begin : g_split
      localparam int H = WIDTH / 2;

      logic [H-1:0] lo_s0, lo_s1, hi_s0, hi_s1;
      logic         lo_co0, lo_co1, hi_co0, hi_co1;

      mul_seq_csa_csa #(.WIDTH(H)) u_lo (
        .x   (x[H-1:0]),
        .y   (y[H-1:0]),
        .s0  (lo_s0),
        .co0 (lo_co0),
        .s1  (lo_s1),
        .co1 (lo_co1)
      );

      mul_seq_csa_csa #(.WIDTH(H)) u_hi (
        .x   (x[WIDTH-1:H]),
        .y   (y[WIDTH-1:H]),
        .s0  (hi_s0),
        .co0 (hi_co0),
        .s1  (hi_s1),
        .co1 (hi_co1)
      );

      // The low half's carry selects which precomputed upper result to keep.
      assign s0  = {(lo_co0 ? hi_s1 : hi_s0), lo_s0};
      assign co0 = lo_co0 ? hi_co1 : hi_co0;
      assign s1  = {(lo_co1 ? hi_s1 : hi_s0), lo_s1};
      assign co1 = lo_co1 ? hi_co1 : hi_co0;
    end
  endgenerate

endmodule

// File: rtl/mul_seq_csa.sv
// Radix-2 shift-add unsigned multiplier: one conditional-sum addition per cycle,
// WIDTH iterations per product, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one add/shift iteration per cycle, WIDTH cycles total
// DONE  | product held on p with out_valid until out_ready
module mul_seq_csa
  import mul_seq_csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  mul_seq_csa_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   add_x, add_y, add_s;
  logic               add_co;
  logic               accept, last_iter;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign add_x = p_q[2*WIDTH-1:WIDTH];
  assign add_y = p_q[0] ? a_q : '0;

  mul_seq_csa_csa #(.WIDTH(WIDTH)) u_csa (
    .x   (add_x),
    .y   (add_y),
    .s0  (add_s),
    .co0 (add_co),
    .s1  (),
    .co1 ()
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: bus.in_ready = !rst;
      RUN:  bus.busy     = 1'b1;
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Carry-out lands in the top bit, so the full WIDTH+1 sum shifts back in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      p_q   <= {{WIDTH{1'b0}}, bus.b};
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      p_q   <= {add_co, add_s, p_q[WIDTH-1:1]};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.p = p_q;

endmodule

// File: tb/tb_mul_seq_csa.sv
// Directed and randomized checks of mul_seq_csa against a plain a*b model.
module tb_mul_seq_csa;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mul_seq_csa_if #(.WIDTH(W)) bus ();

  mul_seq_csa #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // One full transaction with optional out_ready back-pressure of 'hold' cycles.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold,
                        input string tag);
    logic [2*W-1:0] exp;
    int n;
    int ir_low;
    exp = {{W{1'b0}}, ta} * {{W{1'b0}}, tb};
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_ready"}, bus.in_ready, 1);
    bus.a = ta;
    bus.b = tb;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    step();
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    ir_low = bus.in_ready ? 0 : 1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
      if (!bus.in_ready) ir_low++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_p"}, bus.p, exp);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      step();
      if (!bus.in_ready) ir_low++;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_p"}, bus.p, exp);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    if (!bus.in_ready) ir_low++;
    check({tag, "_ovalid_drop"}, bus.out_valid, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_ready_low_cycles"}, ir_low, W + 1 + hold);
    bus.out_ready = 1'b0;
  endtask

  // Streaming scoreboard: expected products queued at accept, popped at output.
  task automatic stream(input int nops, input bit rnd, input bit check_ii, input string tag);
    logic [2*W-1:0] exp_q[$];
    int sent, done, guard, last_acc;
    bit acc, ret;
    sent = 0;
    done = 0;
    guard = 0;
    last_acc = -1;
    bus.a = rand_op();
    bus.b = rand_op();
    while (done < nops && guard < nops * 60 + 100) begin
      if (rnd) begin
        bus.in_valid  = (sent < nops) && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.in_valid  = (sent < nops);
        bus.out_ready = 1'b1;
      end
      acc = bus.in_valid && bus.in_ready;
      ret = bus.out_valid && bus.out_ready;
      if (ret) begin
        check({tag, "_pending"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check({tag, "_p"}, bus.p, exp_q.pop_front());
        done++;
      end
      if (acc) begin
        exp_q.push_back({{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b});
        if (check_ii && last_acc >= 0) check({tag, "_interval"}, cyc - last_acc, W + 2);
        last_acc = cyc;
        sent++;
      end
      step();
      guard++;
      if (acc) begin
        bus.a = rand_op();
        bus.b = rand_op();
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_completed"}, done, nops);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_p", bus.p, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    run_op(16'd3, 16'd5, 0, "a3b5");
    run_op(16'hFFFF, 16'hFFFF, 0, "max");
    run_op(16'h1234, 16'h0000, 0, "b_zero");
    run_op(16'h0000, 16'hABCD, 0, "a_zero");
    run_op(16'h00FF, 16'h0101, 5, "hold");

    // Abort during the 8th iteration with an edge-misaligned reset.
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    check("midrun_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_p", bus.p, 0);
    check("abort_in_ready", bus.in_ready, 0);
    #13;
    rst = 1'b0;
    step();
    check("abort_still_idle", bus.out_valid, 0);
    run_op(16'd7, 16'd6, 0, "post_abort");

    stream(6, 1'b0, 1'b1, "b2b");
    stream(200, 1'b1, 1'b0, "sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
